// File: rtl/hazard_scoreboard.sv
// Hazard detection for the ID stage: shadows EXE/MEM destinations and stalls on RAW conflicts.
// Optional macro HAZARD_FORWARDING_EN: only load-use conflicts in EXE stall; MEM is covered by forwarding.
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_LEN  = 5,
  parameter int unsigned STALL_CNT_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_ADDR_LEN-1:0]  src1,
  input  logic [REG_ADDR_LEN-1:0]  src2,
  input  logic                     two_src,
  input  logic [REG_ADDR_LEN-1:0]  dest_ID,
  input  logic                     WB_EN_ID,
  input  logic                     MEM_R_EN_ID,
  input  logic                     flush,
  output logic                     hazard_detected,
  output logic [STALL_CNT_LEN-1:0] stall_cnt
);

  typedef struct packed {
    logic                    valid;
    logic [REG_ADDR_LEN-1:0] dest;
    logic                    wb_en;
    logic                    mem_r_en;
  } slot_t;

  slot_t                    exe_q, exe_d;
  logic [STALL_CNT_LEN-1:0] stall_cnt_q, stall_cnt_d;
  logic                     hit_exe_c;

  // A slot only produces a hazard for a real, written, non-zero register.
  function automatic logic slot_match(input slot_t s, input logic [REG_ADDR_LEN-1:0] src,
                                      input logic en);
    return en && s.valid && s.wb_en && (s.dest == src) && (src != '0);
  endfunction

`ifdef HAZARD_FORWARDING_EN
  always_comb begin
    hit_exe_c       = slot_match(exe_q, src1, 1'b1) | slot_match(exe_q, src2, two_src);
    hazard_detected = hit_exe_c & exe_q.mem_r_en;
  end
`else
  slot_t mem_q, mem_d;
  logic  hit_mem_c;
  logic  unused_load_flags_c;

  always_comb begin
    hit_exe_c           = slot_match(exe_q, src1, 1'b1) | slot_match(exe_q, src2, two_src);
    hit_mem_c           = slot_match(mem_q, src1, 1'b1) | slot_match(mem_q, src2, two_src);
    hazard_detected     = hit_exe_c | hit_mem_c;
    unused_load_flags_c = exe_q.mem_r_en ^ mem_q.mem_r_en;
  end

  always_comb begin
    mem_d = exe_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
`endif

  // EXE takes a bubble on stall or squash; the counter saturates rather than wrapping.
  always_comb begin
    exe_d       = '0;
    stall_cnt_d = stall_cnt_q;
    if (!(hazard_detected || flush)) begin
      exe_d = '{valid: 1'b1, dest: dest_ID, wb_en: WB_EN_ID, mem_r_en: MEM_R_EN_ID};
    end
    if (hazard_detected && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_LEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      exe_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      exe_q       <= exe_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-cycle model compare plus directed stall-count checks.
module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  src1, src2, dest_id;
  logic        two_src, wb_en_id, mem_r_en_id, flush;
  logic        hazard;
  logic [15:0] stall_cnt;

  // Narrow-counter instance fed a permanent self-dependency to exercise saturation quickly.
  logic [4:0]  s_src  = 5'd4;
  logic [4:0]  s_zero = 5'd0;
  logic        s_one  = 1'b1;
  logic        s_off  = 1'b0;
  logic        s_haz;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_LEN(5), .STALL_CNT_LEN(16)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .dest_ID(dest_id), .WB_EN_ID(wb_en_id), .MEM_R_EN_ID(mem_r_en_id), .flush(flush),
    .hazard_detected(hazard), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.REG_ADDR_LEN(5), .STALL_CNT_LEN(4)) dut_sat (
    .clk(clk), .rst(rst), .src1(s_src), .src2(s_zero), .two_src(s_off),
    .dest_ID(s_src), .WB_EN_ID(s_one), .MEM_R_EN_ID(s_one), .flush(s_off),
    .hazard_detected(s_haz), .stall_cnt(s_cnt)
  );

  typedef struct {
    bit v;
    int dest;
    bit wb;
    bit ld;
  } rec_t;

  rec_t hist[$];  // hist[0] issued one cycle ago, hist[1] two cycles ago
  int   m_cnt = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit model_hazard();
    for (int a = 0; a < hist.size() && a < 2; a++) begin
      rec_t r = hist[a];
      bit hit = r.v && r.wb &&
                ((src1 != 0 && r.dest == int'(src1)) ||
                 (two_src && src2 != 0 && r.dest == int'(src2)));
      if (hit && (!FWD || (a == 0 && r.ld))) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Entered at posedge+1; inputs stay stable until the next posedge+1.
  task automatic drive(input logic [4:0] s1, input logic [4:0] s2, input logic two,
                       input logic [4:0] d, input logic wb, input logic ld, input logic fl,
                       output logic hz);
    src1 = s1; src2 = s2; two_src = two; dest_id = d;
    wb_en_id = wb; mem_r_en_id = ld; flush = fl;
    @(negedge clk);
    hz = hazard;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    logic hz;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, hz);
  endtask

  task automatic run_dep(input string name, input logic [4:0] pd, input logic pwb,
                         input logic pld, input logic pfl, input int gap,
                         input logic [4:0] c1, input logic [4:0] c2, input logic ctwo,
                         input int exp_stalls);
    logic hz;
    int   stalls = 0;
    int   c0;
    repeat (3) nop();
    c0 = int'(stall_cnt);
    drive(5'd0, 5'd0, 1'b0, pd, pwb, pld, pfl, hz);
    check({name, "_prod_hz"}, hz, 0);
    repeat (gap) nop();
    for (int i = 0; i < 6; i++) begin
      drive(c1, c2, ctwo, 5'd0, 1'b0, 1'b0, 1'b0, hz);
      if (!hz) break;
      stalls++;
    end
    check({name, "_stalls"}, stalls, exp_stalls);
    check({name, "_cnt_delta"}, int'(stall_cnt) - c0, exp_stalls);
  endtask

  initial begin
    logic hz;
    int   c0;
    rst = 1'b0;
    src1 = '0; src2 = '0; two_src = 1'b0; dest_id = '0;
    wb_en_id = 1'b0; mem_r_en_id = 1'b0; flush = 1'b0;

    fork
      forever begin : monitor
        bit exp;
        rec_t r;
        @(negedge clk);
        exp = model_hazard();
        if (mon_en) begin
          check("hazard_detected", hazard, exp);
          check("stall_cnt", stall_cnt, m_cnt);
        end
        if (!rst) begin
          hist.delete();
          m_cnt = 0;
        end else begin
          r.v = !(exp || flush);
          r.dest = int'(dest_id);
          r.wb = wb_en_id;
          r.ld = mem_r_en_id;
          hist.push_front(r);
          if (hist.size() > 2) void'(hist.pop_back());
          if (exp && m_cnt < 65535) m_cnt++;
        end
      end
      begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    check("reset_hazard", hazard, 0);
    check("reset_stall_cnt", stall_cnt, 0);

    // Reset with r3 loaded in a slot and src1 = 3 held throughout.
    drive(5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, hz);
    rst = 1'b0;
    drive(5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, hz);
    drive(5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, hz);
    check("rst_hold_hazard", hz, 0);
    check("rst_hold_stall_cnt", stall_cnt, 0);
    rst = 1'b1;
    drive(5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, hz);
    check("rst_release_hazard", hz, 0);

    run_dep("raw_b2b",      5'd4, 1'b1, 1'b0, 1'b0, 0, 5'd4, 5'd0, 1'b0, FWD ? 0 : 2);
    run_dep("raw_gap1",     5'd4, 1'b1, 1'b0, 1'b0, 1, 5'd4, 5'd0, 1'b0, FWD ? 0 : 1);
    run_dep("ld_use",       5'd5, 1'b1, 1'b1, 1'b0, 0, 5'd0, 5'd5, 1'b1, FWD ? 1 : 2);
    run_dep("ld_gap1",      5'd5, 1'b1, 1'b1, 1'b0, 1, 5'd0, 5'd5, 1'b1, FWD ? 0 : 1);
    run_dep("add_src2",     5'd5, 1'b1, 1'b0, 1'b0, 0, 5'd0, 5'd5, 1'b1, FWD ? 0 : 2);
    run_dep("src2_ignored", 5'd5, 1'b1, 1'b1, 1'b0, 0, 5'd0, 5'd5, 1'b0, 0);
    run_dep("r0_dest",      5'd0, 1'b1, 1'b1, 1'b0, 0, 5'd0, 5'd0, 1'b1, 0);
    run_dep("store_prod",   5'd6, 1'b0, 1'b0, 1'b0, 0, 5'd6, 5'd0, 1'b0, 0);
    run_dep("flush_prod",   5'd7, 1'b1, 1'b1, 1'b1, 0, 5'd7, 5'd0, 1'b0, 0);

    // Flush coinciding with a stall still counts the stall.
    repeat (3) nop();
    drive(5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, hz);
    c0 = int'(stall_cnt);
    drive(5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, hz);
    check("flush_stall_hz", hz, 1);
    check("flush_stall_cnt", int'(stall_cnt) - c0, 1);

    // Reset asserted mid-stall.
    repeat (3) nop();
    drive(5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, hz);
    drive(5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, hz);
    check("midrst_stall_hz", hz, 1);
    rst = 1'b0;
    drive(5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, hz);
    drive(5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, hz);
    check("midrst_hz", hz, 0);
    check("midrst_cnt", stall_cnt, 0);
    rst = 1'b1;
    drive(5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, hz);
    check("midrst_release_hz", hz, 0);

    // Saturation of the narrow counter, then holding at all-ones.
    repeat (45) nop();
    check("sat_cnt", s_cnt, 15);
    repeat (10) nop();
    check("sat_hold_cnt", s_cnt, 15);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Hazard detection stage that sits directly upstream of the controller and drives its `hazard_detected` input. It tracks the destination register and write/load flags of the instructions in EXE and MEM in a two-slot shadow pipeline. It compares these against the source registers of the instruction in ID. On a conflict it asserts `hazard_detected`, which stalls IF/ID and makes the controller emit a bubble (`EXE_NO_OPERATION`, no `WB_EN`/`MEM_W_EN`).

## Interface
- `REG_ADDR_LEN`, 5: register address width.
- `STALL_CNT_LEN`, 16: width of the stall performance counter.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `src1`  in  REG_ADDR_LEN  first source register of the ID instruction.
- `src2`  in  REG_ADDR_LEN  second source register of the ID instruction.
- `two_src`  in  1  ID instruction reads `src2` as a register (R-type, ST, BNE).
- `dest_ID`  in  REG_ADDR_LEN  destination register of the ID instruction.
- `WB_EN_ID`  in  1  controller `WB_EN` for the ID instruction.
- `MEM_R_EN_ID`  in  1  controller `MEM_R_EN` for the ID instruction.
- `flush`  in  1  taken branch/jump; the ID instruction is squashed.
- `hazard_detected`  out  1  stall request to IF/ID and the controller.
- `stall_cnt`  out  STALL_CNT_LEN  saturating count of stall cycles.

## Operation
- Shadow slots EXE and MEM each hold {valid, dest, wb_en, mem_r_en}.
- Match rule: a slot matches a source if all of the following hold: slot valid, slot wb_en = 1, slot dest = source, source ≠ 0.
  - Register 0 never causes a hazard.
- `src1` is always checked. `src2` is checked only when `two_src` = 1.
- `hazard_detected` is combinational from the current ID inputs and the registered slots (rules under Configuration).
- Slot update each rising edge, in priority order:
  - `rst` = 0: both slots cleared (valid = 0). `stall_cnt` cleared.
  - Otherwise MEM ← EXE, and EXE is loaded as follows:
    - If `hazard_detected` = 1 or `flush` = 1: EXE ← bubble (valid = 0).
    - Else: EXE ← {1, `dest_ID`, `WB_EN_ID`, `MEM_R_EN_ID`}.
- `flush` with `hazard_detected` both high: a bubble is inserted and the stall is counted.
- `stall_cnt` increments by 1 on each cycle with `hazard_detected` = 1 and `rst` = 1. It saturates at all-ones and does not wrap.
- The register file writes before it reads within a cycle, so the WB stage is not tracked.

## Timing
- Reset values: both slots invalid, `stall_cnt` = 0, and therefore `hazard_detected` = 0.
- `hazard_detected` has zero-cycle latency from `src1`/`src2`/`two_src`. It has one-cycle latency from the issue of the producing instruction.
- Without forwarding, a dependent instruction stalls:
  - 2 cycles when it immediately follows its producer.
  - 1 cycle when one unrelated instruction sits between them.
- With forwarding, only a load-use dependency stalls, for exactly 1 cycle.
- A stall ends by itself: each stalled cycle inserts a bubble, so the producer advances out of the matched slot.
- Reset asserted mid-stall: `hazard_detected` drops to 0 in the cycle after the reset edge. Nothing from before reset is retained.

## Configuration
- Macro: `HAZARD_FORWARDING_EN`.
- Defined:
  - A match in the EXE slot raises a hazard only if EXE.mem_r_en = 1 (load-use).
  - MEM-slot matches are ignored, because the forwarding unit covers them.
- Undefined:
  - Any match in the EXE or MEM slot raises `hazard_detected`.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `src1` = 3 and the slots previously loaded with dest 3 -> `hazard_detected` = 0, `stall_cnt` = 0.
- Back-to-back RAW, forwarding off:
  - Stimulus: ADD r4 (WB_EN_ID = 1, dest_ID = 4), then next cycle `src1` = 4.
  - Required: `hazard_detected` = 1 for exactly 2 cycles, then 0; `stall_cnt` = 2.
- Load-use, `HAZARD_FORWARDING_EN` defined:
  - Stimulus: LD r5 (MEM_R_EN_ID = 1, WB_EN_ID = 1), then `src2` = 5 with `two_src` = 1.
  - Required: exactly 1 stall cycle.
  - Stimulus: same sequence with ADD r5 as the producer.
  - Required: 0 stall cycles.
- r0 and store producer:
  - Stimulus: ADDI writing r0 followed by `src1` = 0.
  - Required: no stall.
  - Stimulus: ST (WB_EN_ID = 0, dest_ID = 6) followed by `src1` = 6.
  - Required: no stall.
- Flush:
  - Stimulus: issue ADD r7 with `flush` = 1, then `src1` = 7.
  - Required: no stall, because the EXE slot holds a bubble.
- Saturation: force `hazard_detected` high for 2^16 + 5 cycles -> `stall_cnt` = 16'hFFFF and holds.
